// File: rtl/param_forward_hazard_unit.sv
// Operand forwarding selects and issue stall for a pipeline with one multi-cycle unit.
// Define FWD_X0_FILTER_EN to stop register x0 from ever matching a source.
module param_forward_hazard_unit #(
  parameter int NUM_OPS  = 2,
  parameter int NUM_SRC  = 3,
  parameter int ADDR_W   = 5,
  parameter int MC_CNT_W = 6,
  localparam int SEL_W   = $clog2(NUM_SRC + 2)
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       id_valid,
  input  logic [NUM_OPS*ADDR_W-1:0]  id_addr,
  input  logic [ADDR_W-1:0]          id_dest,
  input  logic                       id_regwrite_en,
  input  logic [NUM_SRC*ADDR_W-1:0]  src_addr,
  input  logic [NUM_SRC-1:0]         src_regwrite_en,
  input  logic                       src0_is_load,
  input  logic                       mc_start,
  input  logic [MC_CNT_W-1:0]        mc_lat,
  output logic [NUM_OPS*SEL_W-1:0]   fwd_sel,
  output logic                       stall,
  output logic                       mc_busy
);

`ifdef FWD_X0_FILTER_EN
  localparam bit X0_FILTER = 1'b1;
`else
  localparam bit X0_FILTER = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t                state_reg, state_next;
  logic [MC_CNT_W-1:0]   cnt_reg, cnt_next;
  logic [ADDR_W-1:0]     mc_dest_reg, mc_dest_next;

  logic [NUM_OPS-1:0]    lu_vec;
  logic [NUM_OPS-1:0]    raw_vec;
  logic                  in_busy;
  logic                  waw;
  logic                  strct;
  logic                  stall_int;
  logic                  accept;

  function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
    return !X0_FILTER || (a != '0);
  endfunction

  assign in_busy = (state_reg == BUSY);

  generate
    for (genvar gi = 0; gi < NUM_OPS; gi++) begin : g_op
      logic [ADDR_W-1:0]  opa;
      logic [NUM_SRC-1:0] hit;
      logic               mc_hit;
      logic [SEL_W-1:0]   sel;

      assign opa = id_addr[gi*ADDR_W +: ADDR_W];

      for (genvar gj = 0; gj < NUM_SRC; gj++) begin : g_src
        assign hit[gj] = src_regwrite_en[gj] && (src_addr[gj*ADDR_W +: ADDR_W] == opa) && addr_ok(opa);
      end

      // The multi-cycle result is only on the datapath during DONE.
      assign mc_hit = (state_reg == DONE) && (mc_dest_reg == opa) && addr_ok(opa);

      // Scan oldest to youngest so the nearest source overwrites the rest.
      always_comb begin
        sel = '0;
        if (mc_hit) sel = SEL_W'(NUM_SRC + 1);
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
          if (hit[i]) sel = SEL_W'(i + 1);
        end
      end

      assign lu_vec[gi]  = hit[0] && src0_is_load;
      assign raw_vec[gi] = in_busy && (mc_dest_reg == opa) && addr_ok(opa) && !(|hit);
      assign fwd_sel[gi*SEL_W +: SEL_W] = (resetn && id_valid) ? sel : '0;
    end
  endgenerate

  assign waw       = in_busy && id_regwrite_en && (id_dest == mc_dest_reg) && addr_ok(id_dest);
  assign strct     = in_busy && mc_start;
  assign stall_int = id_valid && ((|lu_vec) || (|raw_vec) || waw || strct);
  assign stall     = resetn && stall_int;
  assign accept    = id_valid && mc_start && !stall_int && !in_busy;
  assign mc_busy   = in_busy;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      mc_dest_reg <= '0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      mc_dest_reg <= mc_dest_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    mc_dest_next = mc_dest_reg;
    case (state_reg)
      BUSY: begin
        if (cnt_reg <= MC_CNT_W'(1)) begin
          state_next = DONE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg - MC_CNT_W'(1);
        end
      end
      default: begin
        state_next = IDLE;
        if (accept) begin
          mc_dest_next = id_dest;
          // A latency of 0 behaves exactly like 1.
          if (mc_lat <= MC_CNT_W'(1)) begin
            state_next = DONE;
            cnt_next   = '0;
          end else begin
            state_next = BUSY;
            cnt_next   = mc_lat - MC_CNT_W'(1);
          end
        end
      end
    endcase
  end

endmodule

// File: tb/tb_param_forward_hazard_unit.sv
// Directed bench for param_forward_hazard_unit (default configuration, 2 ops, 3 sources).
module tb_param_forward_hazard_unit;

  localparam int SEL_W = 3;

  logic        clk = 1'b0;
  logic        resetn;
  logic        id_valid;
  logic [9:0]  id_addr;
  logic [4:0]  id_dest;
  logic        id_regwrite_en;
  logic [14:0] src_addr;
  logic [2:0]  src_regwrite_en;
  logic        src0_is_load;
  logic        mc_start;
  logic [5:0]  mc_lat;
  logic [5:0]  fwd_sel;
  logic        stall;
  logic        mc_busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  param_forward_hazard_unit dut (
    .clk(clk), .resetn(resetn), .id_valid(id_valid), .id_addr(id_addr),
    .id_dest(id_dest), .id_regwrite_en(id_regwrite_en), .src_addr(src_addr),
    .src_regwrite_en(src_regwrite_en), .src0_is_load(src0_is_load),
    .mc_start(mc_start), .mc_lat(mc_lat), .fwd_sel(fwd_sel),
    .stall(stall), .mc_busy(mc_busy)
  );

  function automatic logic [31:0] sel_of(input int k);
    return 32'(fwd_sel[k*SEL_W +: SEL_W]);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
    $display("check %-14s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  initial begin
    resetn = 1'b0; id_valid = 1'b1; id_addr = {5'd3, 5'd5}; id_dest = 5'd0;
    id_regwrite_en = 1'b0; src_addr = {5'd5, 5'd0, 5'd5}; src_regwrite_en = 3'b101;
    src0_is_load = 1'b1; mc_start = 1'b0; mc_lat = 6'd0;

    // Reset holds all outputs low even with a matching, loading source.
    repeat (2) @(negedge clk);
    #1;
    chk("rst_sel0", sel_of(0), 0);
    chk("rst_stall", 32'(stall), 0);
    chk("rst_busy", 32'(mc_busy), 0);

    // Source 0 beats source 2.
    @(negedge clk); resetn = 1'b1; src0_is_load = 1'b0; #1;
    chk("prio_sel0", sel_of(0), 1);
    chk("prio_sel1", sel_of(1), 0);
    chk("prio_stall", 32'(stall), 0);
    @(negedge clk); src_regwrite_en = 3'b100; #1;
    chk("src2_sel0", sel_of(0), 3);

    // Load-use then forwarding from source 1.
    @(negedge clk); id_addr = {5'd7, 5'd1}; src_addr = {5'd0, 5'd0, 5'd7};
    src_regwrite_en = 3'b001; src0_is_load = 1'b1; #1;
    chk("lu_stall", 32'(stall), 1);
    chk("lu_sel1", sel_of(1), 1);
    @(negedge clk); src_addr = {5'd0, 5'd7, 5'd0}; src_regwrite_en = 3'b010; src0_is_load = 1'b0; #1;
    chk("s1_sel1", sel_of(1), 2);
    chk("s1_stall", 32'(stall), 0);
    @(negedge clk); id_valid = 1'b0; #1;
    chk("inv_sel1", sel_of(1), 0);
    chk("inv_stall", 32'(stall), 0);

    // MUL dest 9, latency 4.
    @(negedge clk); id_valid = 1'b1; id_addr = {5'd2, 5'd1}; src_regwrite_en = 3'b000;
    mc_start = 1'b1; id_dest = 5'd9; mc_lat = 6'd4; id_regwrite_en = 1'b1; #1;
    chk("mc_go_stall", 32'(stall), 0);
    chk("mc_go_busy", 32'(mc_busy), 0);
    @(negedge clk); mc_start = 1'b0; id_regwrite_en = 1'b0; id_addr = {5'd2, 5'd9}; #1;
    chk("raw_busy", 32'(mc_busy), 1);
    chk("raw_stall", 32'(stall), 1);
    chk("raw_sel0", sel_of(0), 0);
    @(negedge clk); id_addr = {5'd2, 5'd1}; mc_start = 1'b1; id_dest = 5'd4; mc_lat = 6'd2; #1;
    chk("struct_stall", 32'(stall), 1);
    chk("struct_busy", 32'(mc_busy), 1);
    @(negedge clk); mc_start = 1'b0; id_regwrite_en = 1'b1; id_dest = 5'd9; #1;
    chk("waw_stall", 32'(stall), 1);
    chk("waw_busy", 32'(mc_busy), 1);
    // DONE cycle with a new start (dest 12, latency 3) accepted at the same edge.
    @(negedge clk); id_addr = {5'd2, 5'd9}; mc_start = 1'b1; id_dest = 5'd12; mc_lat = 6'd3; #1;
    chk("done_busy", 32'(mc_busy), 0);
    chk("done_stall", 32'(stall), 0);
    chk("done_sel0", sel_of(0), 4);
    @(negedge clk); mc_start = 1'b0; id_regwrite_en = 1'b0; id_addr = {5'd1, 5'd9}; #1;
    chk("new_busy", 32'(mc_busy), 1);
    chk("old_dest_stall", 32'(stall), 0);
    chk("old_dest_sel0", sel_of(0), 0);
    @(negedge clk); id_addr = {5'd1, 5'd12}; src_addr = {5'd0, 5'd0, 5'd12}; src_regwrite_en = 3'b001; #1;
    chk("bypass_stall", 32'(stall), 0);
    chk("bypass_sel0", sel_of(0), 1);
    @(negedge clk); src_regwrite_en = 3'b000; mc_start = 1'b1; id_dest = 5'd20; mc_lat = 6'd0; #1;
    chk("done2_sel0", sel_of(0), 4);
    chk("done2_busy", 32'(mc_busy), 0);
    // Latency 0 goes straight to DONE.
    @(negedge clk); mc_start = 1'b0; id_addr = {5'd1, 5'd20}; #1;
    chk("lat0_busy", 32'(mc_busy), 0);
    chk("lat0_sel0", sel_of(0), 4);
    @(negedge clk); #1;
    chk("idle_sel0", sel_of(0), 0);

    // Reset in the middle of a long op.
    @(negedge clk); id_addr = {5'd2, 5'd1}; mc_start = 1'b1; id_dest = 5'd9; mc_lat = 6'd10; #1;
    chk("long_go_stall", 32'(stall), 0);
    @(negedge clk); mc_start = 1'b0; id_addr = {5'd2, 5'd9}; #1;
    chk("long_busy", 32'(mc_busy), 1);
    @(negedge clk); #1;
    chk("long_stall", 32'(stall), 1);
    resetn = 1'b0; #1;
    chk("arst_stall", 32'(stall), 0);
    chk("arst_busy", 32'(mc_busy), 0);
    chk("arst_sel0", sel_of(0), 0);
    @(negedge clk); resetn = 1'b1; #1;
    chk("post_stall", 32'(stall), 0);
    chk("post_busy", 32'(mc_busy), 0);

    // Everything at x0.
    @(negedge clk); id_addr = 10'd0; src_addr = 15'd0; src_regwrite_en = 3'b111; src0_is_load = 1'b1; #1;
`ifdef FWD_X0_FILTER_EN
    chk("x0_sel0", sel_of(0), 0);
    chk("x0_stall", 32'(stall), 0);
`else
    chk("x0_sel0", sel_of(0), 1);
    chk("x0_stall", 32'(stall), 1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
